alu_exec_ctrl: RTL
==================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter: bit_width, default 32, datapath width of registers, operands and PC.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: in_valid  input  1  decoded instruction present.
REQ-005 Port: in_ready  output  1  block accepts an instruction this cycle.
REQ-006 Port: in_op  input  4  ALU operation code, 0..13 legal, 14..15 reserved.
REQ-007 Port: in_shift_op  input  2  shift type forwarded to ALU.
REQ-008 Port: in_rd, in_rs1, in_rs2  input  4 each  destination and source register indices.
REQ-009 Port: in_use_imm  input  1  select in_imm instead of rs2 value as operand B.
REQ-010 Port: in_imm  input  bit_width  immediate operand.
REQ-011 Port: alu_op  output  4, alu_shift_op  output  2, alu_a / alu_b / alu_pc  output  bit_width  drive the downstream ALU.
REQ-012 Port: alu_r  input  bit_width  combinational ALU result.
REQ-013 Port: wb_valid  output  1, wb_rd  output  4, wb_data  output  bit_width  writeback observation.
REQ-014 Port: pc  output  bit_width  current program counter.
REQ-015 Port: err  output  1  sticky reserved-opcode flag.

Function
REQ-016 Register file SHALL hold 16 entries of bit_width; r0 SHALL read as 0 and ignore writes; r15 SHALL alias pc (read returns pc, write loads pc).
REQ-017 FSM SHALL have states IDLE, EXEC, WB; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on in_valid&in_ready SHALL latch op, shift_op, rd, A=reg[rs1], B=(in_use_imm ? in_imm : reg[rs2]) and move to EXEC; otherwise stay.
REQ-019 EXEC: alu_op/alu_shift_op/alu_a/alu_b SHALL present latched values, alu_pc SHALL present pc+1 (mod 2^bit_width); alu_r SHALL be registered into a result register; move to WB.
REQ-020 In states other than EXEC the alu_* outputs SHALL hold their last latched values (no glitch requirement, ALU result ignored).
REQ-021 WB: wb_valid SHALL be 1 for exactly one cycle with wb_rd=latched rd and wb_data=result; move to IDLE.
REQ-022 WB with rd in 1..14 SHALL write result to reg[rd] and set pc=pc+1.
REQ-023 WB with rd=15 SHALL set pc=result (jump; OUT_T/OUT_F yield pc+1 when not taken); no +1 is added.
REQ-024 WB with rd=0 SHALL discard the result and set pc=pc+1.
REQ-025 Reserved op 14 or 15: no register or pc write other than pc=pc+1, wb_valid still pulses with wb_data=0, err SHALL set to 1 and stay until reset.
REQ-026 Latency: accept to wb_valid SHALL be exactly 2 cycles; throughput one instruction per 3 cycles.
REQ-027 Operands read at accept SHALL see all writes from previous WB (write completes before next IDLE read; no forwarding needed).
REQ-028 pc SHALL wrap from 2^bit_width-1 to 0.
REQ-029 in_* inputs SHALL be ignored outside IDLE.

Reset
REQ-030 rst=1 SHALL, at the next edge, force state IDLE, pc=0, all registers 0, err=0, wb_valid=0, alu_* outputs 0.
REQ-031 rst asserted in EXEC or WB SHALL abandon the instruction with no register/pc write; rst has priority over all other events.
REQ-032 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-033 After reset, issue ADD rd=1 rs1=0 imm=5 -> wb_valid 2 cycles later, wb_data=5, r1=5, pc=1.
REQ-034 Back-to-back: ADD r2=r1+imm 3 immediately after REQ-033 -> r2=8, in_ready low 2 cycles between accepts, pc=2.
REQ-035 OUT_T rd=15 rs1=r3 (r3=all ones) imm=0x40 -> pc=0x40; repeat with r3=0 -> pc=old pc+1.
REQ-036 op=14 rd=4 -> r4 unchanged, wb_data=0, err=1 and stays 1 through later legal instructions until rst.
REQ-037 rst asserted during EXEC of write to r5 -> r5=0, pc=0, no wb_valid pulse, in_ready=1 the cycle after rst drops.
REQ-038 Write to r0 then read r0 as rs1 -> operand A=0; pc at 0xFFFFFFFF plus any non-jump instruction -> pc=0.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: three-state sequencer that feeds one decoded instruction
// at a time to an external combinational ALU and writes the result back
// into a 16-entry register file whose top entry aliases the program counter.
module alu_exec_ctrl #(
   parameter int unsigned bit_width = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic [1:0]           in_shift_op,
   input  logic [3:0]           in_rd,
   input  logic [3:0]           in_rs1,
   input  logic [3:0]           in_rs2,
   input  logic                 in_use_imm,
   input  logic [bit_width-1:0] in_imm,
   output logic [3:0]           alu_op,
   output logic [1:0]           alu_shift_op,
   output logic [bit_width-1:0] alu_a,
   output logic [bit_width-1:0] alu_b,
   output logic [bit_width-1:0] alu_pc,
   input  logic [bit_width-1:0] alu_r,
   output logic                 wb_valid,
   output logic [3:0]           wb_rd,
   output logic [bit_width-1:0] wb_data,
   output logic [bit_width-1:0] pc,
   output logic                 err
);

   localparam int unsigned NUM_REGS = 16;
   localparam logic [3:0]  REG_ZERO = 4'd0;
   localparam logic [3:0]  REG_PC   = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [bit_width-1:0] rf [NUM_REGS];
   logic [3:0]           rd_q;
   logic                 accept;
   logic                 reserved;
   logic [bit_width-1:0] op_a;
   logic [bit_width-1:0] op_b;
   logic [bit_width-1:0] pc_inc;

   // Ops 14 and 15 are reserved; the latched opcode identifies them.
   assign reserved = (alu_op[3:1] == 3'b111);
   assign accept   = in_valid & in_ready;
   assign pc_inc   = pc + bit_width'(1);

   // Register-file read ports: r0 is hard zero, r15 returns the pc.
   always_comb begin
      op_a = rf[in_rs1];
      op_b = rf[in_rs2];
      if (in_rs1 == REG_ZERO) op_a = '0;
      else if (in_rs1 == REG_PC) op_a = pc;
      if (in_rs2 == REG_ZERO) op_b = '0;
      else if (in_rs2 == REG_PC) op_b = pc;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: IDLE waits for an instruction, then EXEC and WB.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake output: ready only when idle and not being reset.
   always_comb begin
      in_ready = 1'b0;
      if ((state == IDLE) && !rst) in_ready = 1'b1;
   end

   // Datapath: operand latch on accept, result capture in EXEC, writeback in WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_op       <= '0;
         alu_shift_op <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_pc       <= '0;
         rd_q         <= '0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         pc           <= '0;
         err          <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else begin
         wb_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  alu_op       <= in_op;
                  alu_shift_op <= in_shift_op;
                  alu_a        <= op_a;
                  alu_b        <= in_use_imm ? in_imm : op_b;
                  alu_pc       <= pc_inc;
                  rd_q         <= in_rd;
               end
            end
            EXEC: begin
               wb_valid <= 1'b1;
               wb_rd    <= rd_q;
               wb_data  <= reserved ? '0 : alu_r;
               if (reserved) err <= 1'b1;
            end
            WB: begin
               if (!reserved && (rd_q == REG_PC)) pc <= wb_data;
               else                               pc <= pc_inc;
               if (!reserved && (rd_q != REG_ZERO) && (rd_q != REG_PC))
                  rf[rd_q] <= wb_data;
            end
            default: ;
         endcase
      end
   end

endmodule
